// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: word-addressed data memory with a fixed
// access latency, stall generation for the upstream stages and WB bubbling.
module mem_access_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AddrMEM,
    input  logic [31:0] StoreDataMEM,
    input  logic        MemReadMEM,
    input  logic        MemWriteMEM,
    input  logic [4:0]  WriteRegInMEM,
    input  logic        RegWriteInMEM,
    input  logic        MemtoRegInMEM,
    output logic [31:0] ReadDataMEM,
    output logic [31:0] ResultMEM,
    output logic [4:0]  WriteRegMEM,
    output logic        RegWriteMEM,
    output logic        MemtoRegMEM,
    output logic        StallMEM,
    output logic [31:0] StallCount
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LAST = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [31:0]       mem_q [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       stall_count_q, stall_count_d;
    logic [ADDR_W-1:0] index_s;
    logic              access_s;
    logic              stall_s;
    logic              complete_s;
    logic              mem_we_s;

    assign index_s     = AddrMEM[ADDR_W+1:2];
    assign access_s    = MemReadMEM | MemWriteMEM;
    assign ReadDataMEM = mem_q[index_s];
    assign ResultMEM   = AddrMEM;
    assign StallMEM    = stall_s;
    assign StallCount  = stall_count_q;

    // Access sequencing: stall for WAIT_CYCLES cycles, then complete.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_s    = 1'b0;
        complete_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access_s) begin
                    if (NO_WAIT) begin
                        complete_s = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                        cnt_d   = WAIT_LAST;
                        state_d = S_WAIT;
                    end
                end else begin
                    complete_s = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    complete_s = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // Reset overrides everything and aborts any in-flight access.
        if (reset) begin
            stall_s    = 1'b0;
            complete_s = 1'b0;
            state_d    = S_IDLE;
            cnt_d      = 4'd0;
        end else begin
            stall_s    = stall_s;
        end
    end

    // Stall counter next value and memory write enable.
    always_comb begin
        mem_we_s = complete_s & MemWriteMEM;
        if (stall_s) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Controls pass to MEM/WB only when not stalled and not in reset.
    always_comb begin
        if (stall_s || reset) begin
            WriteRegMEM = 5'd0;
            RegWriteMEM = 1'b0;
            MemtoRegMEM = 1'b0;
        end else begin
            WriteRegMEM = WriteRegInMEM;
            RegWriteMEM = RegWriteInMEM;
            MemtoRegMEM = MemtoRegInMEM;
        end
    end

    // Sequencer state and stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Data memory is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[index_s] <= StoreDataMEM;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven, scoreboard-checked bench for mem_access_stage with
// WAIT_CYCLES=2 (instance A) and WAIT_CYCLES=0 (instance B).
module tb_mem_access_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_rd, a_wr, a_regw_in, a_m2r_in;
    logic [31:0] a_addr, a_sdata;
    logic [4:0]  a_wreg_in;
    logic [31:0] a_rdata, a_result, a_scount;
    logic [4:0]  a_wreg;
    logic        a_regw, a_m2r, a_stall;

    logic        b_reset, b_rd, b_wr, b_regw_in, b_m2r_in;
    logic [31:0] b_addr, b_sdata;
    logic [4:0]  b_wreg_in;
    logic [31:0] b_rdata, b_result, b_scount;
    logic [4:0]  b_wreg;
    logic        b_regw, b_m2r, b_stall;

    mem_access_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(a_reset), .AddrMEM(a_addr), .StoreDataMEM(a_sdata),
        .MemReadMEM(a_rd), .MemWriteMEM(a_wr), .WriteRegInMEM(a_wreg_in),
        .RegWriteInMEM(a_regw_in), .MemtoRegInMEM(a_m2r_in),
        .ReadDataMEM(a_rdata), .ResultMEM(a_result), .WriteRegMEM(a_wreg),
        .RegWriteMEM(a_regw), .MemtoRegMEM(a_m2r), .StallMEM(a_stall),
        .StallCount(a_scount)
    );

    mem_access_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(b_reset), .AddrMEM(b_addr), .StoreDataMEM(b_sdata),
        .MemReadMEM(b_rd), .MemWriteMEM(b_wr), .WriteRegInMEM(b_wreg_in),
        .RegWriteInMEM(b_regw_in), .MemtoRegInMEM(b_m2r_in),
        .ReadDataMEM(b_rdata), .ResultMEM(b_result), .WriteRegMEM(b_wreg),
        .RegWriteMEM(b_regw), .MemtoRegMEM(b_m2r), .StallMEM(b_stall),
        .StallCount(b_scount)
    );

    // ctl = {reset, MemRead, MemWrite, RegWriteIn, MemtoRegIn}
    // exp_ctl = {StallMEM, RegWriteMEM, MemtoRegMEM}
    typedef struct {
        logic        sel;
        logic [4:0]  ctl;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  wreg;
        logic [2:0]  exp_ctl;
        logic [4:0]  exp_wreg;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_cnt;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic sel, input logic [4:0] ctl, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [4:0] wreg, input logic [2:0] ectl,
                                input logic [4:0] ewreg, input logic chk, input logic [31:0] erd,
                                input logic [31:0] ecnt);
        vec_t v;
        v.sel = sel; v.ctl = ctl; v.addr = addr; v.sdata = sdata; v.wreg = wreg;
        v.exp_ctl = ectl; v.exp_wreg = ewreg; v.chk_rd = chk; v.exp_rd = erd; v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a_reset = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_regw_in = 1'b0; a_m2r_in = 1'b0;
        a_addr = 32'd0; a_sdata = 32'd0; a_wreg_in = 5'd0;
        b_reset = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_regw_in = 1'b0; b_m2r_in = 1'b0;
        b_addr = 32'd0; b_sdata = 32'd0; b_wreg_in = 5'd0;
        if (v.sel == 1'b0) begin
            {a_reset, a_rd, a_wr, a_regw_in, a_m2r_in} = v.ctl;
            a_addr = v.addr; a_sdata = v.sdata; a_wreg_in = v.wreg;
        end else begin
            {b_reset, b_rd, b_wr, b_regw_in, b_m2r_in} = v.ctl;
            b_addr = v.addr; b_sdata = v.sdata; b_wreg_in = v.wreg;
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        vec_t        e;
        logic [2:0]  o_ctl;
        logic [4:0]  o_wreg;
        logic [31:0] o_rd, o_res, o_cnt;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        if (e.sel == 1'b0) begin
            o_ctl = {a_stall, a_regw, a_m2r}; o_wreg = a_wreg;
            o_rd = a_rdata; o_res = a_result; o_cnt = a_scount;
        end else begin
            o_ctl = {b_stall, b_regw, b_m2r}; o_wreg = b_wreg;
            o_rd = b_rdata; o_res = b_result; o_cnt = b_scount;
        end
        check("stall", row, 32'(o_ctl[2]), 32'(e.exp_ctl[2]));
        check("regwrite", row, 32'(o_ctl[1]), 32'(e.exp_ctl[1]));
        check("memtoreg", row, 32'(o_ctl[0]), 32'(e.exp_ctl[0]));
        check("writereg", row, 32'(o_wreg), 32'(e.exp_wreg));
        check("result", row, o_res, e.addr);
        check("stallcount", row, o_cnt, e.exp_cnt);
        if (e.chk_rd) begin
            check("readdata", row, o_rd, e.exp_rd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic done;

        // Instance A (WAIT_CYCLES=2)
        vecs.push_back(mk(1'b0, 5'b11010, 32'h10, 32'h0, 5'd5, 3'b000, 5'd0, 1'b1, 32'h0, 32'd0));
        vecs.push_back(mk(1'b0, 5'b00010, 32'h2A, 32'h0, 5'd3, 3'b010, 5'd3, 1'b1, 32'h0, 32'd0));
        vecs.push_back(mk(1'b0, 5'b00100, 32'h10, 32'hDEADBEEF, 5'd0, 3'b100, 5'd0, 1'b1, 32'h0, 32'd0));
        vecs.push_back(mk(1'b0, 5'b00100, 32'h10, 32'hDEADBEEF, 5'd0, 3'b100, 5'd0, 1'b1, 32'h0, 32'd1));
        vecs.push_back(mk(1'b0, 5'b00100, 32'h10, 32'hDEADBEEF, 5'd0, 3'b000, 5'd0, 1'b1, 32'h0, 32'd2));
        vecs.push_back(mk(1'b0, 5'b01011, 32'h10, 32'h0, 5'd8, 3'b100, 5'd0, 1'b1, 32'hDEADBEEF, 32'd2));
        vecs.push_back(mk(1'b0, 5'b01011, 32'h10, 32'h0, 5'd8, 3'b100, 5'd0, 1'b1, 32'hDEADBEEF, 32'd3));
        vecs.push_back(mk(1'b0, 5'b01011, 32'h10, 32'h0, 5'd8, 3'b011, 5'd8, 1'b1, 32'hDEADBEEF, 32'd4));
        vecs.push_back(mk(1'b0, 5'b00010, 32'h2A, 32'h0, 5'd3, 3'b010, 5'd3, 1'b1, 32'h0, 32'd4));
        vecs.push_back(mk(1'b0, 5'b00010, 32'h2A, 32'h0, 5'd3, 3'b010, 5'd3, 1'b1, 32'h0, 32'd4));
        vecs.push_back(mk(1'b0, 5'b01111, 32'h400, 32'hA5A5A5A5, 5'd9, 3'b100, 5'd0, 1'b1, 32'h0, 32'd4));
        vecs.push_back(mk(1'b0, 5'b01111, 32'h400, 32'hA5A5A5A5, 5'd9, 3'b100, 5'd0, 1'b1, 32'h0, 32'd5));
        vecs.push_back(mk(1'b0, 5'b01111, 32'h400, 32'hA5A5A5A5, 5'd9, 3'b011, 5'd9, 1'b1, 32'h0, 32'd6));
        vecs.push_back(mk(1'b0, 5'b01011, 32'h0, 32'h0, 5'd10, 3'b100, 5'd0, 1'b1, 32'hA5A5A5A5, 32'd6));
        vecs.push_back(mk(1'b0, 5'b01011, 32'h0, 32'h0, 5'd10, 3'b100, 5'd0, 1'b1, 32'hA5A5A5A5, 32'd7));
        vecs.push_back(mk(1'b0, 5'b01011, 32'h0, 32'h0, 5'd10, 3'b011, 5'd10, 1'b1, 32'hA5A5A5A5, 32'd8));
        vecs.push_back(mk(1'b0, 5'b00000, 32'h10, 32'h0, 5'd0, 3'b000, 5'd0, 1'b1, 32'hDEADBEEF, 32'd8));
        vecs.push_back(mk(1'b0, 5'b00000, 32'h13, 32'h0, 5'd0, 3'b000, 5'd0, 1'b1, 32'hDEADBEEF, 32'd8));
        vecs.push_back(mk(1'b0, 5'b00110, 32'h20, 32'h12345678, 5'd4, 3'b100, 5'd0, 1'b1, 32'h0, 32'd8));
        vecs.push_back(mk(1'b0, 5'b10110, 32'h20, 32'h12345678, 5'd4, 3'b000, 5'd0, 1'b1, 32'h0, 32'd9));
        vecs.push_back(mk(1'b0, 5'b00110, 32'h20, 32'h12345678, 5'd4, 3'b100, 5'd0, 1'b1, 32'h0, 32'd0));
        vecs.push_back(mk(1'b0, 5'b00110, 32'h20, 32'h12345678, 5'd4, 3'b100, 5'd0, 1'b1, 32'h0, 32'd1));
        vecs.push_back(mk(1'b0, 5'b00110, 32'h20, 32'h12345678, 5'd4, 3'b010, 5'd4, 1'b1, 32'h0, 32'd2));
        vecs.push_back(mk(1'b0, 5'b00000, 32'h20, 32'h0, 5'd0, 3'b000, 5'd0, 1'b1, 32'h12345678, 32'd2));
        vecs.push_back(mk(1'b0, 5'b00100, 32'h30, 32'h0BAD0001, 5'd0, 3'b100, 5'd0, 1'b1, 32'h0, 32'd2));
        vecs.push_back(mk(1'b0, 5'b00100, 32'h30, 32'h0BAD0001, 5'd0, 3'b100, 5'd0, 1'b1, 32'h0, 32'd3));
        vecs.push_back(mk(1'b0, 5'b00100, 32'h30, 32'h0BAD0001, 5'd0, 3'b000, 5'd0, 1'b1, 32'h0, 32'd4));
        vecs.push_back(mk(1'b0, 5'b00100, 32'h34, 32'h0BAD0002, 5'd0, 3'b100, 5'd0, 1'b1, 32'h0, 32'd4));
        vecs.push_back(mk(1'b0, 5'b00100, 32'h34, 32'h0BAD0002, 5'd0, 3'b100, 5'd0, 1'b1, 32'h0, 32'd5));
        vecs.push_back(mk(1'b0, 5'b00100, 32'h34, 32'h0BAD0002, 5'd0, 3'b000, 5'd0, 1'b1, 32'h0, 32'd6));
        vecs.push_back(mk(1'b0, 5'b00000, 32'h30, 32'h0, 5'd0, 3'b000, 5'd0, 1'b1, 32'h0BAD0001, 32'd6));
        vecs.push_back(mk(1'b0, 5'b00000, 32'h34, 32'h0, 5'd0, 3'b000, 5'd0, 1'b1, 32'h0BAD0002, 32'd6));

        // Power-up reset of both instances
        a_reset = 1'b1; a_rd = 1'b0; a_wr = 1'b0; a_regw_in = 1'b0; a_m2r_in = 1'b0;
        a_addr = 32'd0; a_sdata = 32'd0; a_wreg_in = 5'd0;
        b_reset = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_regw_in = 1'b0; b_m2r_in = 1'b0;
        b_addr = 32'd0; b_sdata = 32'd0; b_wreg_in = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Held load on A: count stall cycles under a cycle budget.
        a_reset = 1'b0; a_rd = 1'b1; a_wr = 1'b0; a_addr = 32'h10;
        a_regw_in = 1'b1; a_m2r_in = 1'b1; a_wreg_in = 5'd8;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            if (a_stall) begin
                n++;
                check("bubble_regwrite", 200, 32'(a_regw), 32'd0);
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
                check("done_readdata", 200, a_rdata, 32'hDEADBEEF);
                check("done_writereg", 200, 32'(a_wreg), 32'd8);
                check("done_regwrite", 200, 32'(a_regw), 32'd1);
            end
        end
        check("seq_completed", 200, 32'(done), 32'd1);
        check("seq_stall_cycles", 200, 32'(n), 32'd2);
        @(posedge clk);
        #1;
        a_rd = 1'b0; a_regw_in = 1'b0; a_m2r_in = 1'b0; a_wreg_in = 5'd0;
        @(negedge clk);
        check("seq_stallcount", 201, a_scount, 32'd8);
        check("seq_idle_stall", 201, 32'(a_stall), 32'd0);
        @(posedge clk);
        #1;

        // Instance B (WAIT_CYCLES=0)
        vecs.delete();
        vecs.push_back(mk(1'b1, 5'b00100, 32'h0, 32'h11111111, 5'd0, 3'b000, 5'd0, 1'b1, 32'h0, 32'd0));
        vecs.push_back(mk(1'b1, 5'b00100, 32'h4, 32'h22222222, 5'd0, 3'b000, 5'd0, 1'b1, 32'h0, 32'd0));
        vecs.push_back(mk(1'b1, 5'b00100, 32'h8, 32'h33333333, 5'd0, 3'b000, 5'd0, 1'b1, 32'h0, 32'd0));
        vecs.push_back(mk(1'b1, 5'b01011, 32'h0, 32'h0, 5'd1, 3'b011, 5'd1, 1'b1, 32'h11111111, 32'd0));
        vecs.push_back(mk(1'b1, 5'b01011, 32'h4, 32'h0, 5'd2, 3'b011, 5'd2, 1'b1, 32'h22222222, 32'd0));
        vecs.push_back(mk(1'b1, 5'b01011, 32'h8, 32'h0, 5'd3, 3'b011, 5'd3, 1'b1, 32'h33333333, 32'd0));
        vecs.push_back(mk(1'b1, 5'b01111, 32'hC, 32'h44444444, 5'd7, 3'b011, 5'd7, 1'b1, 32'h0, 32'd0));
        vecs.push_back(mk(1'b1, 5'b01011, 32'hC, 32'h0, 5'd7, 3'b011, 5'd7, 1'b1, 32'h44444444, 32'd0));
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], 100 + i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
